// File: rtl/mem_access_unit.sv
// Y86 memory stage: decodes icode into a data-memory read or write, runs a
// req/ack handshake bounded by a timeout, and reports valM plus AOK/ADR status.
module mem_access_unit #(
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 8192,
  parameter int TIMEOUT   = 15,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valP,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] valM,
  output logic              busy,
  output logic              done,
  output logic [2:0]        stat
);

  localparam logic [2:0]        STAT_AOK   = 3'd1;
  localparam logic [2:0]        STAT_ADR   = 3'd3;
  // Highest byte address at which a full DATA_W word still fits in memory.
  localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(MEM_BYTES - DATA_W / 8);
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_mem_req;
  logic               w_mem_req_next;
  logic               r_mem_we;
  logic               w_mem_we_next;
  logic [DATA_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  w_mem_addr_next;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [DATA_W-1:0]  w_mem_wdata_next;
  logic [DATA_W-1:0]  r_valm;
  logic [DATA_W-1:0]  w_valm_next;
  logic               r_busy;
  logic               w_busy_next;
  logic               r_done;
  logic               w_done_next;
  logic [2:0]         r_stat;
  logic [2:0]         w_stat_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [CNT_W-1:0]   w_cnt_inc;

  logic               w_dec_access;
  logic               w_dec_we;
  logic [DATA_W-1:0]  w_dec_addr;
  logic [DATA_W-1:0]  w_dec_wdata;
  logic               w_in_range;

  always_comb begin
    w_dec_access = 1'b0;
    w_dec_we     = 1'b0;
    w_dec_addr   = '0;
    w_dec_wdata  = '0;
    case (icode)
      4'h4: begin
        w_dec_access = 1'b1;
        w_dec_we     = 1'b1;
        w_dec_addr   = valE;
        w_dec_wdata  = valA;
      end
      4'h5: begin
        w_dec_access = 1'b1;
        w_dec_addr   = valE;
      end
      4'h8: begin
        w_dec_access = 1'b1;
        w_dec_we     = 1'b1;
        w_dec_addr   = valE;
        w_dec_wdata  = valP;
      end
      4'hA: begin
        w_dec_access = 1'b1;
        w_dec_we     = 1'b1;
        w_dec_addr   = valE;
        w_dec_wdata  = valA;
      end
      4'h9, 4'hB: begin
        w_dec_access = 1'b1;
        w_dec_addr   = valA;
      end
      default: begin
        w_dec_access = 1'b0;
      end
    endcase
  end

  // Full-width unsigned compare, so addresses near the top of the space never wrap in range.
  assign w_in_range = (w_dec_addr <= ADDR_LIMIT);
  assign w_cnt_inc  = r_cnt + 1'b1;

  always_comb begin
    w_state_next     = r_state;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_valm_next      = r_valm;
    w_busy_next      = 1'b0;
    w_done_next      = 1'b0;
    w_stat_next      = r_stat;
    w_cnt_next       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_stat_next = STAT_AOK;
          if (!w_dec_access) begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
          end else if (!w_in_range) begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
            w_stat_next  = STAT_ADR;
          end else begin
            w_state_next     = S_REQ;
            w_mem_req_next   = 1'b1;
            w_mem_we_next    = w_dec_we;
            w_mem_addr_next  = w_dec_addr;
            w_mem_wdata_next = w_dec_wdata;
            w_busy_next      = 1'b1;
            w_cnt_next       = '0;
          end
        end
      end
      S_REQ: begin
        w_busy_next = 1'b1;
        // Ack is tested first so a response on the final allowed cycle still counts.
        if (mem_ack) begin
          w_state_next   = S_DONE;
          w_mem_req_next = 1'b0;
          w_busy_next    = 1'b0;
          w_done_next    = 1'b1;
          w_stat_next    = STAT_AOK;
          if (!r_mem_we) begin
            w_valm_next = mem_rdata;
          end
        end else if (w_cnt_inc == CNT_LIMIT) begin
          w_state_next   = S_DONE;
          w_mem_req_next = 1'b0;
          w_busy_next    = 1'b0;
          w_done_next    = 1'b1;
          w_stat_next    = STAT_ADR;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next   = S_IDLE;
        w_mem_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_valm      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stat      <= STAT_AOK;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_valm      <= w_valm_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_stat      <= w_stat_next;
      r_cnt       <= w_cnt_next;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign valM      = r_valm;
  assign busy      = r_busy;
  assign done      = r_done;
  assign stat      = r_stat;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the SEQ memory stage.
- Decodes icode into a read or write of data memory, then drives a req/ack handshake that tolerates multi-cycle memory latency.
- Checks address bounds, bounds each access with a timeout, and returns valM plus a Y86 status code.
- Sits between the Execute stage and the data memory; the stage controller stalls on busy.

Parameters:
- DATA_W, 64, data and address width in bits; multiple of 8.
- MEM_BYTES, 8192, size of the addressable data memory in bytes.
- TIMEOUT, 15, maximum cycles to wait for mem_ack before flagging ADR; must be at least 1.
- CNT_W, 4, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse: icode/valE/valA/valP are valid.
- icode  in  4  instruction code.
- valE  in  DATA_W  ALU result.
- valA  in  DATA_W  register operand A.
- valP  in  DATA_W  next PC.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_W  byte address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  memory completion.
- mem_rdata  in  DATA_W  read data; valid with mem_ack.
- valM  out  DATA_W  read result.
- busy  out  1  access in progress.
- done  out  1  one-cycle completion pulse.
- stat  out  3  status: 1 = AOK, 3 = ADR.

Behaviour:
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, valM=0, busy=0, done=0, stat=1. State is IDLE, counter is 0. Reset applies immediately, mid-access included; any outstanding request is abandoned.
- Decode, registered at the start edge:
  - 4 (rmmovq): write, addr=valE, data=valA.
  - 5 (mrmovq): read, addr=valE.
  - 8 (call): write, addr=valE, data=valP.
  - A (pushq): write, addr=valE, data=valA.
  - 9 (ret): read, addr=valA.
  - B (popq): read, addr=valA.
  - Any other icode: no access.
- Bounds check: addr is in range when addr <= MEM_BYTES - DATA_W/8. Compute it at full DATA_W width with no wrap; addresses near 2^DATA_W are out of range.
- FSM states:
  - IDLE, on start:
    - No-access icode -> DONE; stat=1; valM unchanged.
    - Out-of-range address -> DONE; stat=3; no request issued.
    - Otherwise -> REQ; mem_req=1, mem_we/mem_addr/mem_wdata latched, busy=1, counter cleared.
  - REQ:
    - mem_req, mem_addr, mem_wdata and mem_we are held stable until exit.
    - mem_ack=1 -> DONE; mem_req=0 in the next cycle; valM <= mem_rdata on reads, unchanged on writes; stat=1.
    - No ack -> counter increments.
    - Counter == TIMEOUT with no ack -> DONE; mem_req=0; stat=3.
    - Ack and timeout in the same cycle: ack wins, stat=1.
  - DONE: done=1 and busy=0 for exactly one cycle, then -> IDLE. stat holds until the next start.
- Minimum latency: start to done is 2 cycles when the ack arrives in the first REQ cycle, and 1 cycle for no-access or out-of-range.
- busy is 1 only in REQ.
- start while busy or in DONE is ignored.
- mem_ack outside REQ is ignored.
- stat is sticky only until the next accepted start, which resets it to 1 before evaluation.

Test Plan:
- rst mid-REQ, with mem_req=1: mem_req, busy and done go to 0 immediately and stat=1. The next start is accepted normally.
- mrmovq, valE=0x100, ack after 3 cycles with mem_rdata=0xDEADBEEF: mem_req=1, mem_we=0, mem_addr=0x100 held for 3 cycles. Then valM=0xDEADBEEF, done pulses once, stat=1.
- pushq, valE=0x1FF8, valA=0x55, immediate ack: mem_we=1, mem_addr=0x1FF8, mem_wdata=0x55. This is the last legal address for the default MEM_BYTES; done arrives 2 cycles after start, stat=1.
- rmmovq, valE=0x1FF9, and separately valE=0xFFFFFFFFFFFFFFFC: mem_req never asserts; done 1 cycle after start; stat=3.
- ret, valA=0x40, ack never arrives: done after TIMEOUT=15 REQ cycles, then mem_req=0, stat=3. A repeat run with ack exactly on cycle 15 must give stat=1.
- nop (icode 1) gives done with no request and stat=1. A start pulsed during a REQ is ignored, and mem_addr stays unchanged.
